ushift_reg: RTL

- Parametrised successor to the team's single-bit set/clear/enable flops: a WIDTH-bit universal shift register with the same control-priority scheme.
- Supports load, logical shift, rotate and arithmetic shift.
- Adds a multi-cycle burst-shift engine: one start shifts by amt positions, one position per enabled cycle, with busy/done handshake.
- Used as a datapath register for serial links and shift-and-add arithmetic.

---
 rtl/ushift_pkg.sv | 27 ++
 rtl/ushift_step.sv | 51 +++++
 rtl/ushift_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/ushift_pkg.sv
// ushift_pkg: shared types for the universal shift register.
//   mode_t   - operation select (hold/load/shifts/rotates/asr/reserved)
//   state_t  - burst engine state
//   is_shift - true for modes that move one bit position per step
package ushift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHL  = 3'b010,
    SHR  = 3'b011,
    ROTL = 3'b100,
    ROTR = 3'b101,
    ASR  = 3'b110,
    RSVD = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic logic is_shift(input mode_t m);
    return (m == SHL) || (m == SHR) || (m == ROTL) || (m == ROTR) || (m == ASR);
  endfunction

endpackage

// File: rtl/ushift_step.sv
// ushift_step: combinational one-position shifter shared by the single-op
// path and the burst path.
//   q_i       - current register value
//   sin_i     - serial fill bit for shl/shr
//   mode_i    - shift flavour; non-shift modes pass q_i through
//   next_q_o  - value after one position
//   out_bit_o - bit leaving the register (0 for non-shift modes)
module ushift_step
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             sin_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             out_bit_o
);

  always_comb begin
    next_q_o  = q_i;
    out_bit_o = 1'b0;
    case (mode_i)
      SHL: begin
        next_q_o  = {q_i[WIDTH-2:0], sin_i};
        out_bit_o = q_i[WIDTH-1];
      end
      SHR: begin
        next_q_o  = {sin_i, q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
      ROTL: begin
        next_q_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_bit_o = q_i[WIDTH-1];
      end
      ROTR: begin
        next_q_o  = {q_i[0], q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
      ASR: begin
        next_q_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_bit_o = q_i[0];
      end
      default: begin
        next_q_o  = q_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ushift_reg.sv
// ushift_reg: WIDTH-bit universal shift register with set/clr priority and
// a burst engine that shifts amt positions, one per enabled cycle.
//   clk, rst_n    - clock, async active-low reset
//   set, clr      - sync force to ones / zeros, abort any burst
//   en            - enable; low holds q and stalls a burst
//   mode          - operation select (ushift_pkg::mode_t encoding)
//   d, sin        - parallel load data, serial fill bit
//   start, amt    - launch a burst of the current shift mode, amt steps
//   q, sout       - register contents, last bit shifted out
//   busy, done    - burst in progress, one-cycle completion pulse
module ushift_reg
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  mode_t            bmode_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] q_q;
  logic             sout_q;
  logic             done_q;

  mode_t            mode_in;
  mode_t            step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  assign mode_in = mode_t'(mode);

  // During a burst the latched mode drives the shifter; the live mode
  // input is ignored.
  assign step_mode = (state_q == BURST) ? bmode_q : mode_in;

  ushift_step #(.WIDTH(WIDTH)) u_step (
    .q_i      (q_q),
    .sin_i    (sin),
    .mode_i   (step_mode),
    .next_q_o (step_q),
    .out_bit_o(step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bmode_q <= HOLD;
      count_q <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (set) begin
        q_q     <= '1;
        state_q <= IDLE;
        count_q <= '0;
      end else if (clr) begin
        q_q     <= '0;
        state_q <= IDLE;
        count_q <= '0;
      end else if (state_q == BURST) begin
        if (en) begin
          q_q     <= step_q;
          sout_q  <= step_out;
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      end else if (en) begin
        if (start && is_shift(mode_in)) begin
          // Start edge only arms the engine; q moves on later edges.
          bmode_q <= mode_in;
          count_q <= amt;
          if (amt != '0) state_q <= BURST;
          else           done_q  <= 1'b1;
        end else if (mode_in == LOAD) begin
          q_q <= d;
        end else if (is_shift(mode_in)) begin
          q_q    <= step_q;
          sout_q <= step_out;
        end
      end
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule
